// File: rtl/fast_corner_detect_pkg.sv
// Shared FAST-9 definitions: scan states, arc/ring sizes and the Bresenham
// radius-3 ring offsets, also used by the orientation stage.
package fast_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StEval, StDone} state_e;

  localparam int unsigned ARC_LEN = 9;
  localparam int unsigned RING_N  = 16;

  // Clockwise from 12 o'clock.
  localparam logic signed [2:0] RING_DX [RING_N] = '{
    3'sd0, 3'sd1, 3'sd2, 3'sd3, 3'sd3, 3'sd3, 3'sd2, 3'sd1,
    3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
  };
  localparam logic signed [2:0] RING_DY [RING_N] = '{
    -3'sd3, -3'sd3, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2, 3'sd3,
    3'sd3, 3'sd3, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2, -3'sd3
  };

endpackage

// File: rtl/fast_corner_detect_if.sv
// Start/threshold request, image SRAM read port and corner report of the detector.
interface fast_corner_detect_if #(
  parameter int unsigned X_MAX       = 16,
  parameter int unsigned Y_MAX       = 16,
  parameter int unsigned PIXEL_DEPTH = 8
);
  localparam int unsigned XW = $clog2(X_MAX) + 1;
  localparam int unsigned YW = $clog2(Y_MAX) + 1;

  logic                   start_detect;
  logic [PIXEL_DEPTH-1:0] threshold;
  logic                   ren_img;
  logic [XW-1:0]          x_addr_img;
  logic [YW-1:0]          y_addr_img;
  logic [PIXEL_DEPTH-1:0] rdat_img;
  logic                   corner_valid;
  logic [XW-1:0]          corner_x;
  logic [YW-1:0]          corner_y;
  logic                   corner_dark;
  logic                   busy;
  logic                   detect_done;
  logic                   err;

  modport master (
    input  start_detect, threshold, rdat_img,
    output ren_img, x_addr_img, y_addr_img, corner_valid, corner_x, corner_y,
           corner_dark, busy, detect_done, err
  );

  modport slave (
    output start_detect, threshold, rdat_img,
    input  ren_img, x_addr_img, y_addr_img, corner_valid, corner_x, corner_y,
           corner_dark, busy, detect_done, err
  );

endinterface

// File: rtl/fast_corner_detect_arc_check.sv
// Flags any run of ARC_LEN set bits in a circular RING_N-bit vector.
module fast_arc_check
  import fast_pkg::*;
(
  input  logic [RING_N-1:0] vec_i,
  output logic              arc_o
);

  // Unrolled copy so every rotation is a plain part-select.
  logic [RING_N+ARC_LEN-2:0] vec_ext;
  assign vec_ext = {vec_i[ARC_LEN-2:0], vec_i};

  always_comb begin
    arc_o = 1'b0;
    for (int s = 0; s < RING_N; s++) begin
      arc_o = arc_o | (&vec_ext[s +: ARC_LEN]);
    end
  end

endmodule

// File: rtl/fast_corner_detect.sv
// Raster scan of a blurred frame running the FAST-9 segment test on every interior
// pixel; 19 cycles per candidate (17 reads, capture, evaluate).
module fast_corner_detect
  import fast_pkg::*;
#(
  parameter int unsigned X_MAX       = 16,
  parameter int unsigned Y_MAX       = 16,
  parameter int unsigned PIXEL_DEPTH = 8
) (
  input logic                 clk,
  input logic                 n_rst,
  fast_corner_detect_if.master bus
);

  localparam int unsigned XW        = $clog2(X_MAX) + 1;
  localparam int unsigned YW        = $clog2(Y_MAX) + 1;
  localparam bit          HasCand   = (X_MAX >= 7) && (Y_MAX >= 7);
  localparam logic [4:0]  FetchLast = 5'(RING_N + 1);
  localparam logic [XW-1:0] XFirst  = XW'(3);
  localparam logic [YW-1:0] YFirst  = YW'(3);
  localparam logic [XW-1:0] XLast   = XW'(X_MAX - 4);
  localparam logic [YW-1:0] YLast   = YW'(Y_MAX - 4);

  state_e                 state_q, state_d;
  logic [4:0]             idx_q, idx_d;
  logic [XW-1:0]          cx_q, cx_d;
  logic [YW-1:0]          cy_q, cy_d;
  logic [PIXEL_DEPTH-1:0] thr_q, thr_d;
  logic [PIXEL_DEPTH-1:0] cen_q, cen_d;
  logic [RING_N-1:0]      bright_q, bright_d;
  logic [RING_N-1:0]      dark_q, dark_d;
  logic                   cv_q, cv_d;
  logic [XW-1:0]          cxo_q, cxo_d;
  logic [YW-1:0]          cyo_q, cyo_d;
  logic                   cdark_q, cdark_d;
  logic                   err_q, err_d;

  logic                   busy, ren;
  logic [XW-1:0]          x_addr;
  logic [YW-1:0]          y_addr;
  logic [3:0]             ring_sel;
  logic [PIXEL_DEPTH:0]   c_plus_t, p_plus_t;
  logic                   is_bright, is_dark, arc_bright, arc_dark;

  fast_arc_check u_arc_bright (.vec_i(bright_q), .arc_o(arc_bright));
  fast_arc_check u_arc_dark   (.vec_i(dark_q),   .arc_o(arc_dark));

  assign busy     = (state_q != StIdle);
  assign ring_sel = idx_q[3:0] - 4'd1;
  // One extra bit so c + t and p + t never wrap.
  assign c_plus_t  = {1'b0, cen_q} + {1'b0, thr_q};
  assign p_plus_t  = {1'b0, bus.rdat_img} + {1'b0, thr_q};
  assign is_bright = ({1'b0, bus.rdat_img} > c_plus_t);
  assign is_dark   = (p_plus_t < {1'b0, cen_q});

  always_comb begin
    ren    = (state_q == StFetch) && (idx_q < FetchLast);
    x_addr = '0;
    y_addr = '0;
    if (ren) begin
      if (idx_q == 5'd0) begin
        x_addr = cx_q;
        y_addr = cy_q;
      end else begin
        x_addr = cx_q + XW'(RING_DX[ring_sel]);
        y_addr = cy_q + YW'(RING_DY[ring_sel]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    thr_d    = thr_q;
    cen_d    = cen_q;
    bright_d = bright_q;
    dark_d   = dark_q;
    cv_d     = 1'b0;
    cxo_d    = cxo_q;
    cyo_d    = cyo_q;
    cdark_d  = cdark_q;
    err_d    = bus.start_detect && busy;
    unique case (state_q)
      StIdle: begin
        if (bus.start_detect) begin
          thr_d   = bus.threshold;
          cx_d    = XFirst;
          cy_d    = YFirst;
          idx_d   = '0;
          state_d = HasCand ? StFetch : StDone;
        end
      end
      StFetch: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd1) cen_d = bus.rdat_img;
        // Ring datum k arrives at idx k+2; after 16 shifts ring 0 sits in bit 0.
        if (idx_q >= 5'd2) begin
          bright_d = {is_bright, bright_q[RING_N-1:1]};
          dark_d   = {is_dark, dark_q[RING_N-1:1]};
        end
        if (idx_q == FetchLast) state_d = StEval;
      end
      StEval: begin
        idx_d = '0;
        if (arc_bright || arc_dark) begin
          cv_d    = 1'b1;
          cxo_d   = cx_q;
          cyo_d   = cy_q;
          cdark_d = !arc_bright;
        end
        state_d = StFetch;
        if (cx_q == XLast) begin
          cx_d = XFirst;
          if (cy_q == YLast) state_d = StDone;
          else               cy_d    = cy_q + YW'(1);
        end else begin
          cx_d = cx_q + XW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      thr_q    <= '0;
      cen_q    <= '0;
      bright_q <= '0;
      dark_q   <= '0;
      cv_q     <= 1'b0;
      cxo_q    <= '0;
      cyo_q    <= '0;
      cdark_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      thr_q    <= thr_d;
      cen_q    <= cen_d;
      bright_q <= bright_d;
      dark_q   <= dark_d;
      cv_q     <= cv_d;
      cxo_q    <= cxo_d;
      cyo_q    <= cyo_d;
      cdark_q  <= cdark_d;
      err_q    <= err_d;
    end
  end

  assign bus.ren_img      = ren;
  assign bus.x_addr_img   = x_addr;
  assign bus.y_addr_img   = y_addr;
  assign bus.corner_valid = cv_q;
  assign bus.corner_x     = cxo_q;
  assign bus.corner_y     = cyo_q;
  assign bus.corner_dark  = cdark_q;
  assign bus.busy         = busy;
  assign bus.detect_done  = (state_q == StDone);
  assign bus.err          = err_q;

endmodule

// File: tb/tb_fast_corner_detect.sv
// Directed bench for fast_corner_detect: behavioural image SRAM plus strobe monitor.
module tb_fast_corner_detect;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;

  fast_corner_detect_if bus ();

  fast_corner_detect dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int rdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int rdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  logic [7:0]  img [16][16];
  logic [10:0] strobes [$];
  int n_done = 0;
  int n_err  = 0;
  int n_asserts = 0;
  int n_fail    = 0;

  always @(posedge clk) begin
    if (bus.ren_img) bus.rdat_img <= img[bus.y_addr_img[3:0]][bus.x_addr_img[3:0]];
  end

  always @(negedge clk) begin
    if (bus.corner_valid) strobes.push_back({bus.corner_dark, bus.corner_y, bus.corner_x});
    if (bus.detect_done) n_done <= n_done + 1;
    if (bus.err) n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = v;
  endtask

  task automatic set_ring(input int k, input logic [7:0] v);
    img[6 + rdy[k]][6 + rdx[k]] = v;
  endtask

  task automatic start_scan(input logic [7:0] thr);
    bus.threshold = thr;
    @(negedge clk);
    bus.start_detect = 1'b1;
    @(negedge clk);
    bus.start_detect = 1'b0;
  endtask

  // Returns cycles from the call until detect_done, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 2500; k++) begin
      if (bus.detect_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic int find_strobe(input int from, input int x, input int y);
    int r = -1;
    for (int i = from; i < strobes.size(); i++) begin
      if (int'(strobes[i][4:0]) == x && int'(strobes[i][9:5]) == y) r = int'(strobes[i][10]);
    end
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ren"}, int'(bus.ren_img), 0);
    chk({tag, "_xaddr"}, int'(bus.x_addr_img), 0);
    chk({tag, "_yaddr"}, int'(bus.y_addr_img), 0);
    chk({tag, "_cvalid"}, int'(bus.corner_valid), 0);
    chk({tag, "_cx"}, int'(bus.corner_x), 0);
    chk({tag, "_cy"}, int'(bus.corner_y), 0);
    chk({tag, "_cdark"}, int'(bus.corner_dark), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.detect_done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
  endtask

  task automatic single_dark_image();
    fill(8'h10);
    img[8][8] = 8'hF0;
  endtask

  initial begin
    int lat, s0, d0, e0;
    bus.start_detect = 1'b0;
    bus.threshold    = '0;
    #1 n_rst = 1'b0;
    #10 chk_idle("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Flat frame, plus the address sequence of candidate (3,3).
    fill(8'h80);
    s0 = strobes.size();
    d0 = n_done;
    start_scan(8'd20);
    chk("addr_ren0", int'(bus.ren_img), 1);
    chk("addr_x0", int'(bus.x_addr_img), 3);
    chk("addr_y0", int'(bus.y_addr_img), 3);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("addr_ren%0d", k + 1), int'(bus.ren_img), 1);
      chk($sformatf("addr_x%0d", k + 1), int'(bus.x_addr_img), 3 + rdx[k]);
      chk($sformatf("addr_y%0d", k + 1), int'(bus.y_addr_img), 3 + rdy[k]);
    end
    @(negedge clk);
    chk("ren_capture", int'(bus.ren_img), 0);
    @(negedge clk);
    chk("ren_eval", int'(bus.ren_img), 0);
    @(negedge clk);
    chk("next_cand_x", int'(bus.x_addr_img), 4);
    chk("next_cand_y", int'(bus.y_addr_img), 3);
    wait_done(lat);
    chk("flat_latency", lat + 19, 1900);
    chk("flat_strobes", strobes.size() - s0, 0);
    chk("flat_done", n_done - d0, 1);

    // Single bright pixel on a dark background.
    single_dark_image();
    s0 = strobes.size();
    start_scan(8'd20);
    wait_done(lat);
    chk("single_strobes", strobes.size() - s0, 1);
    chk("single_x", int'(strobes[s0][4:0]), 8);
    chk("single_y", int'(strobes[s0][9:5]), 8);
    chk("single_dark", int'(strobes[s0][10]), 1);

    // Arc wrapping from index 15 to 0.
    fill(8'h40);
    for (int k = 12; k < 16; k++) set_ring(k, 8'h80);
    for (int k = 0; k < 5; k++) set_ring(k, 8'h80);
    s0 = strobes.size();
    start_scan(8'd10);
    wait_done(lat);
    chk("wrap9_at66", find_strobe(s0, 6, 6), 0);
    set_ring(4, 8'h40);
    s0 = strobes.size();
    start_scan(8'd10);
    wait_done(lat);
    chk("wrap8_at66", find_strobe(s0, 6, 6), -1);

    // Threshold equality is not a corner; one above is.
    fill(8'h40);
    for (int k = 0; k < 16; k++) set_ring(k, 8'h50);
    s0 = strobes.size();
    start_scan(8'h10);
    wait_done(lat);
    chk("thr_equal", find_strobe(s0, 6, 6), -1);
    for (int k = 0; k < 16; k++) set_ring(k, 8'h51);
    s0 = strobes.size();
    start_scan(8'h10);
    wait_done(lat);
    chk("thr_above", find_strobe(s0, 6, 6), 0);

    // Start while busy.
    single_dark_image();
    s0 = strobes.size();
    d0 = n_done;
    e0 = n_err;
    start_scan(8'd20);
    repeat (299) @(negedge clk);
    bus.start_detect = 1'b1;
    @(negedge clk);
    bus.start_detect = 1'b0;
    wait_done(lat);
    chk("err_pulses", n_err - e0, 1);
    chk("err_strobes", strobes.size() - s0, 1);
    chk("err_corner", find_strobe(s0, 8, 8), 1);
    chk("err_done", n_done - d0, 1);
    chk("err_total_latency", lat + 300, 1900);

    // Reset mid-scan.
    s0 = strobes.size();
    d0 = n_done;
    start_scan(8'd20);
    repeat (499) @(negedge clk);
    #2 n_rst = 1'b0;
    #1 chk_idle("midreset");
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2500) @(negedge clk);
    chk("post_reset_strobes", strobes.size() - s0, 0);
    chk("post_reset_done", n_done - d0, 0);
    chk("post_reset_busy", int'(bus.busy), 0);

    s0 = strobes.size();
    d0 = n_done;
    start_scan(8'd20);
    wait_done(lat);
    chk("rerun_latency", lat, 1900);
    chk("rerun_strobes", strobes.size() - s0, 1);
    chk("rerun_corner", find_strobe(s0, 8, 8), 1);
    chk("rerun_done", n_done - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
